// File: rtl/execute_muldiv.sv
// EX stage with operand forwarding, 1-cycle ALU and an iterative mul/div unit.
// Define EXEC_MULDIV_DIV_EN to build the divider (DIV/DIVU/REM/REMU).
module execute_muldiv #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic              i_flush,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_reg_write,
    input  logic              i_alu_src,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_mem_to_reg,
    input  logic [3:0]        i_alu_ctrl,
    input  logic [REG_AW-1:0] i_ex_mem_rd,
    input  logic [REG_AW-1:0] i_mem_wb_rd,
    input  logic              i_ex_mem_reg_write,
    input  logic              i_mem_wb_reg_write,
    input  logic [XLEN-1:0]   i_ex_mem_result,
    input  logic [XLEN-1:0]   i_mem_wb_data,
    output logic              o_stall,
    output logic [XLEN-1:0]   o_ex_mem_result,
    output logic [XLEN-1:0]   o_ex_mem_write_data,
    output logic [REG_AW-1:0] o_ex_mem_rd,
    output logic              o_ex_mem_reg_write,
    output logic              o_ex_mem_mem_read,
    output logic              o_ex_mem_mem_write,
    output logic              o_ex_mem_mem_to_reg
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_wdata;
    logic [REG_AW-1:0] r_rd;
    logic              r_rw;
    logic              r_mr;
    logic              r_mw;
    logic              r_mtr;
    logic              r_high;

    logic [XLEN-1:0]   w_a;
    logic [XLEN-1:0]   w_fwd_b;
    logic [XLEN-1:0]   w_b;
    logic [XLEN-1:0]   w_alu;
    logic [XLEN-1:0]   w_done;
    logic [XLEN:0]     w_sum;
    logic              w_multi;
    logic              w_unused;

    assign w_unused = ^i_pc;

    // EX/MEM wins over MEM/WB; x0 is never forwarded
    assign w_a =
        (i_ex_mem_reg_write && i_ex_mem_rd == i_rs1 && i_rs1 != '0) ? i_ex_mem_result :
        (i_mem_wb_reg_write && i_mem_wb_rd == i_rs1 && i_rs1 != '0) ? i_mem_wb_data :
        i_rs1_data;

    assign w_fwd_b =
        (i_ex_mem_reg_write && i_ex_mem_rd == i_rs2 && i_rs2 != '0) ? i_ex_mem_result :
        (i_mem_wb_reg_write && i_mem_wb_rd == i_rs2 && i_rs2 != '0) ? i_mem_wb_data :
        i_rs2_data;

    assign w_b = i_alu_src ? i_imm : w_fwd_b;

    always_comb begin
        w_alu = '0;
        case (i_alu_ctrl)
            4'b0000: w_alu = w_a & w_b;
            4'b0001: w_alu = w_a | w_b;
            4'b0010: w_alu = w_a + w_b;
            4'b0110: w_alu = w_a - w_b;
            4'b0111: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            default: w_alu = '0;
        endcase
    end

    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

`ifdef EXEC_MULDIV_DIV_EN
    logic              r_is_div;
    logic [1:0]        r_dop;
    logic              r_dz;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_a;

    logic              w_sgn;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_shl;
    logic [XLEN:0]     w_diff;

    assign w_multi = (i_alu_ctrl[3:1] == 3'b100) || (i_alu_ctrl[3:2] == 2'b11);

    // signed ops run on magnitudes, signs are restored at the end
    assign w_sgn   = ~i_alu_ctrl[0];
    assign w_neg_a = w_sgn & w_a[XLEN-1];
    assign w_neg_b = w_sgn & w_b[XLEN-1];
    assign w_mag_a = w_neg_a ? (~w_a + 1'b1) : w_a;
    assign w_mag_b = w_neg_b ? (~w_b + 1'b1) : w_b;
    assign w_shl   = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shl - {1'b0, r_b};
`else
    assign w_multi = (i_alu_ctrl[3:1] == 3'b100);
`endif

    always_comb begin
        w_done = r_high ? r_hi : r_lo;
`ifdef EXEC_MULDIV_DIV_EN
        if (r_is_div) begin
            case (r_dop)
                2'b00:   w_done = r_dz ? '1 : (r_neg_q ? (~r_lo + 1'b1) : r_lo);
                2'b01:   w_done = r_dz ? '1 : r_lo;
                2'b10:   w_done = r_dz ? r_a : (r_neg_r ? (~r_hi + 1'b1) : r_hi);
                default: w_done = r_dz ? r_a : r_hi;
            endcase
        end
`endif
    end

    assign o_stall = i_reset && !i_flush &&
                     ((r_state == S_IDLE && i_valid && w_multi) || r_state == S_BUSY);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state             <= S_IDLE;
            r_cnt               <= '0;
            o_ex_mem_result     <= '0;
            o_ex_mem_write_data <= '0;
            o_ex_mem_rd         <= '0;
            o_ex_mem_reg_write  <= 1'b0;
            o_ex_mem_mem_read   <= 1'b0;
            o_ex_mem_mem_write  <= 1'b0;
            o_ex_mem_mem_to_reg <= 1'b0;
        end else begin
            o_ex_mem_result     <= '0;
            o_ex_mem_write_data <= '0;
            o_ex_mem_rd         <= '0;
            o_ex_mem_reg_write  <= 1'b0;
            o_ex_mem_mem_read   <= 1'b0;
            o_ex_mem_mem_write  <= 1'b0;
            o_ex_mem_mem_to_reg <= 1'b0;
            if (i_flush) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (i_valid && w_multi) begin
                            r_state <= S_BUSY;
                            r_cnt   <= CW'(XLEN);
                            r_high  <= i_alu_ctrl[0];
                            r_rd    <= i_rd;
                            r_rw    <= i_reg_write;
                            r_mr    <= i_mem_read;
                            r_mw    <= i_mem_write;
                            r_mtr   <= i_mem_to_reg;
                            r_wdata <= w_fwd_b;
                            r_hi    <= '0;
`ifdef EXEC_MULDIV_DIV_EN
                            r_is_div <= i_alu_ctrl[2];
                            r_dop    <= i_alu_ctrl[1:0];
                            r_dz     <= (w_b == '0);
                            r_neg_q  <= w_neg_a ^ w_neg_b;
                            r_neg_r  <= w_neg_a;
                            r_a      <= w_a;
                            if (i_alu_ctrl[2]) begin
                                r_lo <= w_mag_a;
                                r_b  <= w_mag_b;
                            end else
`endif
                            begin
                                r_lo <= w_a;
                                r_b  <= w_b;
                            end
                        end else if (i_valid) begin
                            o_ex_mem_result     <= w_alu;
                            o_ex_mem_write_data <= w_fwd_b;
                            o_ex_mem_rd         <= i_rd;
                            o_ex_mem_reg_write  <= i_reg_write;
                            o_ex_mem_mem_read   <= i_mem_read;
                            o_ex_mem_mem_write  <= i_mem_write;
                            o_ex_mem_mem_to_reg <= i_mem_to_reg;
                        end
                    end
                    S_BUSY: begin
`ifdef EXEC_MULDIV_DIV_EN
                        if (r_is_div) begin
                            if (!w_diff[XLEN]) begin
                                r_hi <= w_diff[XLEN-1:0];
                                r_lo <= {r_lo[XLEN-2:0], 1'b1};
                            end else begin
                                r_hi <= w_shl[XLEN-1:0];
                                r_lo <= {r_lo[XLEN-2:0], 1'b0};
                            end
                        end else
`endif
                        begin
                            r_hi <= w_sum[XLEN:1];
                            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                        end
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) r_state <= S_DONE;
                    end
                    S_DONE: begin
                        o_ex_mem_result     <= w_done;
                        o_ex_mem_write_data <= r_wdata;
                        o_ex_mem_rd         <= r_rd;
                        o_ex_mem_reg_write  <= r_rw;
                        o_ex_mem_mem_read   <= r_mr;
                        o_ex_mem_mem_write  <= r_mw;
                        o_ex_mem_mem_to_reg <= r_mtr;
                        r_state             <= S_IDLE;
                        r_cnt               <= '0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
